mpf_vtp_tlb_port_responder: RTL and testbench
=============================================

# mpf_vtp_tlb_port_responder

Responder end of a VTP translation port. It accepts the translation requests that request-side translators issue for their read and write channels, and looks up the virtual line address in a small fully-associative TLB. It returns either the translated physical line address or an error, in request order. Software or a page-walker preloads the TLB through a fill port. The block sits between a translation channel and the (absent or simplified) page-table walker, and serves as the VTP service in reduced systems and benches.

## Interface
- N_ENTRIES, 16: TLB entries; power of 2, range 2..64.
- ADDR_WIDTH, 42: line-address width of requests and responses.
- PAGE_LINE_BITS, 6: low line-address bits that are the in-page offset (4KB page, 64B line).
- TAG_WIDTH, 8: opaque requester tag, returned unchanged.
- OUT_DEPTH, 4: response FIFO depth; power of 2, at least 2.
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_WIDTH  line address.
- req_addr_is_virtual  in  1  0 = pass through untranslated.
- req_is_speculative  in  1  a miss is reported as an error but is not fatal.
- req_tag  in  TAG_WIDTH  opaque tag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_addr  out  ADDR_WIDTH  translated address, or req_addr on miss/pass-through.
- rsp_error  out  1  translation miss.
- rsp_tag  out  TAG_WIDTH  tag of the request.
- fill_valid  in  1  write one TLB mapping.
- fill_va_page  in  ADDR_WIDTH-PAGE_LINE_BITS  virtual page number.
- fill_pa_page  in  ADDR_WIDTH-PAGE_LINE_BITS  physical page number.
- inval_all  in  1  clear all TLB entries.
- fatal_miss  out  1  sticky; a non-speculative virtual request missed.
- hit_count, miss_count  out  32 each  saturating statistics.

## Operation
- Pipeline:
  - S0 accepts the request into the stage-1 register.
  - S1 compares the VPN (req_addr[ADDR_WIDTH-1:PAGE_LINE_BITS]) against all valid entries.
  - The S1 result is written into the response FIFO at the end of the S1 cycle.
- Hit: rsp_addr = {entry PPN, req_addr[PAGE_LINE_BITS-1:0]}, rsp_error=0; hit_count increments.
- Miss (virtual, no valid match): rsp_addr = req_addr, rsp_error=1; miss_count increments.
  - If not speculative, fatal_miss is also set. It stays set until reset.
  - The pipeline never blocks on a miss.
- Pass-through (req_addr_is_virtual=0): rsp_addr = req_addr, rsp_error=0, no lookup, no counter change.
- Multiple matching entries cannot occur, because fill dedups. The bench checks this.
- Fill:
  - If the VPN matches a valid entry, that entry's PPN is overwritten.
  - Otherwise the entry at the round-robin victim pointer is written and marked valid, and the pointer increments modulo N_ENTRIES.
- inval_all: clears all valid bits and resets the victim pointer to 0. It wins over a same-cycle fill, and that fill is dropped.
- Lookup/fill ordering: S1 compares against TLB state as of the start of its cycle. A fill or invalidate at edge E affects only lookups in S1 cycles after E.
- Responses leave strictly in acceptance order.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - Outputs: rsp_valid=0, fatal_miss=0, hit_count=0, miss_count=0. req_ready=1 from the first cycle after reset.
  - State: all TLB valid bits 0, victim pointer 0, FIFO empty, S1 empty.
- Reset mid-operation discards S1 and the FIFO contents without emitting responses.
- Latency: a request accepted at edge E appears as rsp_valid in the cycle after edge E+1, provided the FIFO is empty. That is 2 cycles, from acceptance to the response becoming visible.
- Throughput: 1 request/cycle while rsp_ready=1.
- Credit rule: req_ready = (FIFO occupancy + S1 valid) < OUT_DEPTH. The FIFO therefore never overflows and S1 never stalls.
- Backpressure: rsp_data is stable while rsp_valid && !rsp_ready.
- Full FIFO plus a simultaneous dequeue: req_ready is computed from registered occupancy. One cycle of lost issue opportunity is acceptable.
- Fill is single-cycle; there is no fill backpressure.

## Test plan
- Basic hit:
  - Stimulus: fill VPN 0x100 → PPN 0x7A2, then request addr {0x100, 6'h15}, virtual, tag 0x3C.
  - Expected: 2 cycles later, rsp_addr={0x7A2, 6'h15}, rsp_error=0, tag 0x3C; hit_count=1.
- Speculative and non-speculative misses:
  - Stimulus: speculative miss on VPN 0x200.
  - Expected: rsp_addr=req_addr, rsp_error=1, fatal_miss=0.
  - Stimulus: a following non-speculative miss.
  - Expected: fatal_miss=1 and it remains set; miss_count=2.
- Pass-through: request 0x1234 with virtual=0 on an empty TLB → rsp_addr=0x1234, rsp_error=0, counters unchanged.
- Replacement and dedup:
  - Stimulus: fill N_ENTRIES+1 distinct VPNs.
  - Expected: the first VPN misses and the last hits.
  - Stimulus: refill an existing VPN with a new PPN.
  - Expected: the new PPN is returned and the victim pointer does not move.
- Ordering and interactions:
  - Stimulus: fill and inval_all in the same cycle.
  - Expected: the TLB is empty and the fill is lost.
  - Stimulus: fill in the same cycle that S1 holds a matching request.
  - Expected: that request misses and the next one hits.
- Backpressure:
  - Stimulus: hold rsp_ready=0 and stream requests.
  - Expected: exactly OUT_DEPTH are accepted and req_ready drops.
  - Stimulus: release rsp_ready.
  - Expected: responses in order, no loss or duplication; a reset asserted mid-stream leaves rsp_valid=0 the next cycle.

Source files
------------

// File: rtl/mpf_vtp_tlb_port_responder.sv
// VTP translation responder: fully-associative TLB lookup with an in-order response FIFO.
// The TLB is preloaded through a fill port; misses are reported as errors, never stalled on.
module mpf_vtp_tlb_port_responder #(
  parameter int N_ENTRIES      = 16,
  parameter int ADDR_WIDTH     = 42,
  parameter int PAGE_LINE_BITS = 6,
  parameter int TAG_WIDTH      = 8,
  parameter int OUT_DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic                                 req_addr_is_virtual,
  input  logic                                 req_is_speculative,
  input  logic [TAG_WIDTH-1:0]                 req_tag,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [ADDR_WIDTH-1:0]                rsp_addr,
  output logic                                 rsp_error,
  output logic [TAG_WIDTH-1:0]                 rsp_tag,
  input  logic                                 fill_valid,
  input  logic [ADDR_WIDTH-PAGE_LINE_BITS-1:0] fill_va_page,
  input  logic [ADDR_WIDTH-PAGE_LINE_BITS-1:0] fill_pa_page,
  input  logic                                 inval_all,
  output logic                                 fatal_miss,
  output logic [31:0]                          hit_count,
  output logic [31:0]                          miss_count
);

  localparam int PAGE_WIDTH = ADDR_WIDTH - PAGE_LINE_BITS;
  localparam int IDX_WIDTH  = $clog2(N_ENTRIES);
  localparam int PTR_WIDTH  = $clog2(OUT_DEPTH);
  localparam int CNT_WIDTH  = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(OUT_DEPTH);

  logic [N_ENTRIES-1:0]  tlb_valid_q, tlb_valid_d;
  logic [PAGE_WIDTH-1:0] tlb_vpn_q [N_ENTRIES];
  logic [PAGE_WIDTH-1:0] tlb_vpn_d [N_ENTRIES];
  logic [PAGE_WIDTH-1:0] tlb_ppn_q [N_ENTRIES];
  logic [PAGE_WIDTH-1:0] tlb_ppn_d [N_ENTRIES];
  logic [IDX_WIDTH-1:0]  victim_q, victim_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic                  s1_virt_q, s1_virt_d;
  logic                  s1_spec_q, s1_spec_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [OUT_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [OUT_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag_q [OUT_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag_d [OUT_DEPTH];
  logic [OUT_DEPTH-1:0]  fifo_err_q, fifo_err_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic                  fatal_q, fatal_d;
  logic [31:0]           hit_count_q, hit_count_d;
  logic [31:0]           miss_count_q, miss_count_d;

  logic                  lookup_hit;
  logic [PAGE_WIDTH-1:0] lookup_ppn;
  logic                  fill_match;
  logic [IDX_WIDTH-1:0]  fill_idx;
  logic                  is_hit, is_miss, res_err, push, pop;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic [CNT_WIDTH-1:0]  credit_used;

  // Credits are taken from registered occupancy, so S1 can always drain into the FIFO.
  assign credit_used = count_q + CNT_WIDTH'(s1_valid_q);
  assign req_ready   = credit_used < DEPTH;
  assign rsp_valid   = count_q != '0;
  assign rsp_addr    = fifo_addr_q[rd_ptr_q];
  assign rsp_error   = fifo_err_q[rd_ptr_q];
  assign rsp_tag     = fifo_tag_q[rd_ptr_q];
  assign fatal_miss  = fatal_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

  always_comb begin
    lookup_hit = 1'b0;
    lookup_ppn = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (!lookup_hit && tlb_valid_q[i] &&
          tlb_vpn_q[i] == s1_addr_q[ADDR_WIDTH-1:PAGE_LINE_BITS]) begin
        lookup_hit = 1'b1;
        lookup_ppn = tlb_ppn_q[i];
      end
    end
  end

  always_comb begin
    tlb_valid_d = tlb_valid_q;
    tlb_vpn_d   = tlb_vpn_q;
    tlb_ppn_d   = tlb_ppn_q;
    victim_d    = victim_q;
    fill_match  = 1'b0;
    fill_idx    = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (!fill_match && tlb_valid_q[i] && tlb_vpn_q[i] == fill_va_page) begin
        fill_match = 1'b1;
        fill_idx   = IDX_WIDTH'(i);
      end
    end
    // Refilling a mapped VPN updates it in place so no VPN is ever held twice.
    if (inval_all) begin
      tlb_valid_d = '0;
      victim_d    = '0;
    end else if (fill_valid) begin
      if (fill_match) begin
        tlb_ppn_d[fill_idx] = fill_pa_page;
      end else begin
        tlb_valid_d[victim_q] = 1'b1;
        tlb_vpn_d[victim_q]   = fill_va_page;
        tlb_ppn_d[victim_q]   = fill_pa_page;
        victim_d              = victim_q + IDX_WIDTH'(1);
      end
    end
  end

  always_comb begin
    s1_valid_d = req_valid && req_ready;
    s1_addr_d  = s1_addr_q;
    s1_virt_d  = s1_virt_q;
    s1_spec_d  = s1_spec_q;
    s1_tag_d   = s1_tag_q;
    if (s1_valid_d) begin
      s1_addr_d = req_addr;
      s1_virt_d = req_addr_is_virtual;
      s1_spec_d = req_is_speculative;
      s1_tag_d  = req_tag;
    end

    res_addr = s1_addr_q;
    res_err  = 1'b0;
    is_hit   = 1'b0;
    is_miss  = 1'b0;
    if (s1_valid_q && s1_virt_q) begin
      if (lookup_hit) begin
        res_addr = {lookup_ppn, s1_addr_q[PAGE_LINE_BITS-1:0]};
        is_hit   = 1'b1;
      end else begin
        res_err = 1'b1;
        is_miss = 1'b1;
      end
    end

    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (is_hit && hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
    if (is_miss && miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
    fatal_d = fatal_q | (is_miss & ~s1_spec_q);

    push        = s1_valid_q;
    pop         = rsp_valid && rsp_ready;
    fifo_addr_d = fifo_addr_q;
    fifo_tag_d  = fifo_tag_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = res_addr;
      fifo_err_d[wr_ptr_q]  = res_err;
      fifo_tag_d[wr_ptr_q]  = s1_tag_q;
      wr_ptr_d              = wr_ptr_q + PTR_WIDTH'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tlb_valid_q  <= '0;
      victim_q     <= '0;
      s1_valid_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fatal_q      <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      tlb_valid_q  <= tlb_valid_d;
      victim_q     <= victim_d;
      s1_valid_q   <= s1_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fatal_q      <= fatal_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Payload storage is qualified by the valid/pointer state and needs no reset.
  always_ff @(posedge clk) begin
    tlb_vpn_q   <= tlb_vpn_d;
    tlb_ppn_q   <= tlb_ppn_d;
    s1_addr_q   <= s1_addr_d;
    s1_virt_q   <= s1_virt_d;
    s1_spec_q   <= s1_spec_d;
    s1_tag_q    <= s1_tag_d;
    fifo_addr_q <= fifo_addr_d;
    fifo_tag_q  <= fifo_tag_d;
    fifo_err_q  <= fifo_err_d;
  end

endmodule

// File: tb/tb_mpf_vtp_tlb_port_responder.sv
// Bench for mpf_vtp_tlb_port_responder: directed scenarios plus a randomized run
// scored against a slot/round-robin TLB model with an expected-response queue.
module tb_mpf_vtp_tlb_port_responder;
  localparam int NE  = 16;
  localparam int AW  = 42;
  localparam int PLB = 6;
  localparam int TW  = 8;
  localparam int OD  = 4;
  localparam int PW  = AW - PLB;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          err;
    logic [TW-1:0] tag;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_addr_is_virtual = 1'b0, req_is_speculative = 1'b0;
  logic [TW-1:0] req_tag = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_error;
  logic [AW-1:0] rsp_addr;
  logic [TW-1:0] rsp_tag;
  logic          fill_valid = 1'b0, inval_all = 1'b0;
  logic [PW-1:0] fill_va_page = '0, fill_pa_page = '0;
  logic          fatal_miss;
  logic [31:0]   hit_count, miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic          m_valid [NE];
  logic [PW-1:0] m_vpn [NE];
  logic [PW-1:0] m_ppn [NE];
  int            m_victim;
  logic [31:0]   m_hits, m_misses;
  logic          m_fatal;
  logic          pend_valid = 1'b0;
  logic [AW-1:0] pend_addr;
  logic          pend_virt, pend_spec;
  logic [TW-1:0] pend_tag;
  rsp_t          exp_q[$];
  rsp_t          got_q[$];
  logic          last_acc;

  mpf_vtp_tlb_port_responder #(
    .N_ENTRIES(NE), .ADDR_WIDTH(AW), .PAGE_LINE_BITS(PLB), .TAG_WIDTH(TW), .OUT_DEPTH(OD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_addr_is_virtual(req_addr_is_virtual), .req_is_speculative(req_is_speculative),
    .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag),
    .fill_valid(fill_valid), .fill_va_page(fill_va_page), .fill_pa_page(fill_pa_page),
    .inval_all(inval_all), .fatal_miss(fatal_miss),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // One clock: sample at the falling edge, then apply that edge's effects to the model.
  task automatic tick();
    logic s_acc, s_pop, s_rst, s_fill, s_inval, s_virt, s_spec;
    logic [AW-1:0] s_addr;
    logic [TW-1:0] s_tag;
    logic [PW-1:0] s_fva, s_fpa;
    rsp_t s_rsp, r;
    int idx;
    @(negedge clk);
    s_acc = req_valid && req_ready;
    s_pop = rsp_valid && rsp_ready;
    s_rst = !reset_n;
    s_fill = fill_valid; s_inval = inval_all; s_fva = fill_va_page; s_fpa = fill_pa_page;
    s_addr = req_addr; s_virt = req_addr_is_virtual; s_spec = req_is_speculative; s_tag = req_tag;
    s_rsp.addr = rsp_addr; s_rsp.err = rsp_error; s_rsp.tag = rsp_tag;
    @(posedge clk);
    last_acc = s_acc && !s_rst;
    if (s_rst) begin
      for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
      m_victim = 0; m_hits = '0; m_misses = '0; m_fatal = 1'b0;
      pend_valid = 1'b0;
      exp_q.delete(); got_q.delete();
    end else begin
      if (s_pop) got_q.push_back(s_rsp);
      if (pend_valid) begin
        r.addr = pend_addr; r.err = 1'b0; r.tag = pend_tag;
        if (pend_virt) begin
          idx = -1;
          for (int i = 0; i < NE; i++)
            if (m_valid[i] && m_vpn[i] == pend_addr[AW-1:PLB]) idx = i;
          if (idx >= 0) begin
            r.addr = {m_ppn[idx], pend_addr[PLB-1:0]};
            if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
          end else begin
            r.err = 1'b1;
            if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
            if (!pend_spec) m_fatal = 1'b1;
          end
        end
        exp_q.push_back(r);
      end
      if (s_inval) begin
        for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
        m_victim = 0;
      end else if (s_fill) begin
        idx = -1;
        for (int i = 0; i < NE; i++) if (m_valid[i] && m_vpn[i] == s_fva) idx = i;
        if (idx >= 0) m_ppn[idx] = s_fpa;
        else begin
          m_valid[m_victim] = 1'b1; m_vpn[m_victim] = s_fva; m_ppn[m_victim] = s_fpa;
          m_victim = (m_victim + 1) % NE;
        end
      end
      pend_valid = s_acc; pend_addr = s_addr; pend_virt = s_virt;
      pend_spec = s_spec; pend_tag = s_tag;
    end
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; fill_valid = 1'b0; inval_all = 1'b0; rsp_ready = 1'b1;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic do_fill(input logic [PW-1:0] va, input logic [PW-1:0] pa);
    fill_valid = 1'b1; fill_va_page = va; fill_pa_page = pa;
    tick();
    fill_valid = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic v, input logic s, input logic [TW-1:0] t);
    req_addr = a; req_addr_is_virtual = v; req_is_speculative = s; req_tag = t;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    req_valid = 1'b0; fill_valid = 1'b0; inval_all = 1'b0; rsp_ready = 1'b1;
    while ((pend_valid || rsp_valid) && guard < 64) begin tick(); guard++; end
    if (guard >= 64) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL drain_timeout got rsp_valid=%0b after %0d cycles, expected idle", rsp_valid, guard);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready got=%0b exp=1", req_ready); end
    n_checks++; if (fatal_miss !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fatal got=%0b exp=0", fatal_miss); end
    n_checks++; if (hit_count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_hits got=%0d exp=0", hit_count); end
    n_checks++; if (miss_count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_misses got=%0d exp=0", miss_count); end
  endtask

  task automatic test_basic_hit();
    do_fill(36'h100, 36'h7A2);
    issue({36'h100, 6'h15}, 1'b1, 1'b0, 8'h3C);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_latency_early got=%0b exp=0", rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hit_valid got=%0b exp=1", rsp_valid); end
    n_checks++; if (rsp_addr !== {36'h7A2, 6'h15}) begin n_fail++; $display("[TB] FAIL hit_addr got=%h exp=%h", rsp_addr, {36'h7A2, 6'h15}); end
    n_checks++; if (rsp_error !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_error got=%0b exp=0", rsp_error); end
    n_checks++; if (rsp_tag !== 8'h3C) begin n_fail++; $display("[TB] FAIL hit_tag got=%h exp=3c", rsp_tag); end
    n_checks++; if (hit_count !== 32'd1) begin n_fail++; $display("[TB] FAIL hit_count got=%0d exp=1", hit_count); end
  endtask

  task automatic test_miss();
    issue({36'h200, 6'h07}, 1'b1, 1'b1, 8'h41);
    tick();
    n_checks++; if (rsp_addr !== {36'h200, 6'h07}) begin n_fail++; $display("[TB] FAIL spec_miss_addr got=%h exp=%h", rsp_addr, {36'h200, 6'h07}); end
    n_checks++; if (rsp_error !== 1'b1) begin n_fail++; $display("[TB] FAIL spec_miss_error got=%0b exp=1", rsp_error); end
    n_checks++; if (fatal_miss !== 1'b0) begin n_fail++; $display("[TB] FAIL spec_miss_fatal got=%0b exp=0", fatal_miss); end
    issue({36'h201, 6'h02}, 1'b1, 1'b0, 8'h42);
    tick();
    n_checks++; if (rsp_error !== 1'b1) begin n_fail++; $display("[TB] FAIL fatal_miss_error got=%0b exp=1", rsp_error); end
    n_checks++; if (fatal_miss !== 1'b1) begin n_fail++; $display("[TB] FAIL fatal_miss_set got=%0b exp=1", fatal_miss); end
    n_checks++; if (miss_count !== 32'd2) begin n_fail++; $display("[TB] FAIL miss_count got=%0d exp=2", miss_count); end
    repeat (3) tick();
    n_checks++; if (fatal_miss !== 1'b1) begin n_fail++; $display("[TB] FAIL fatal_sticky got=%0b exp=1", fatal_miss); end
  endtask

  task automatic test_passthrough();
    do_reset();
    issue(42'h1234, 1'b0, 1'b0, 8'h55);
    tick();
    n_checks++; if (rsp_addr !== 42'h1234) begin n_fail++; $display("[TB] FAIL pass_addr got=%h exp=1234", rsp_addr); end
    n_checks++; if (rsp_error !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_error got=%0b exp=0", rsp_error); end
    n_checks++; if ({hit_count, miss_count} !== 64'd0) begin n_fail++; $display("[TB] FAIL pass_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
  endtask

  task automatic test_replacement();
    do_reset();
    for (int i = 0; i <= NE; i++) do_fill(36'h300 + 36'(i), 36'h500 + 36'(i));
    issue({36'h300, 6'h01}, 1'b1, 1'b1, 8'h01);
    tick();
    n_checks++; if (rsp_error !== 1'b1) begin n_fail++; $display("[TB] FAIL evicted_first got_err=%0b exp=1", rsp_error); end
    issue({36'h310, 6'h2A}, 1'b1, 1'b1, 8'h02);
    tick();
    n_checks++; if (rsp_addr !== {36'h510, 6'h2A} || rsp_error !== 1'b0) begin n_fail++; $display("[TB] FAIL last_fill_hit got=%h/%0b exp=%h/0", rsp_addr, rsp_error, {36'h510, 6'h2A}); end
    do_fill(36'h305, 36'hABC);
    issue({36'h305, 6'h3F}, 1'b1, 1'b1, 8'h03);
    tick();
    n_checks++; if (rsp_addr !== {36'hABC, 6'h3F}) begin n_fail++; $display("[TB] FAIL refill_ppn got=%h exp=%h", rsp_addr, {36'hABC, 6'h3F}); end
    // A moved victim pointer would evict VPN 0x302 instead of 0x301.
    do_fill(36'h3FF, 36'h777);
    issue({36'h301, 6'h00}, 1'b1, 1'b1, 8'h04);
    tick();
    n_checks++; if (rsp_error !== 1'b1) begin n_fail++; $display("[TB] FAIL refill_victim_evict got_err=%0b exp=1", rsp_error); end
    issue({36'h302, 6'h00}, 1'b1, 1'b1, 8'h05);
    tick();
    n_checks++; if (rsp_addr !== {36'h502, 6'h00} || rsp_error !== 1'b0) begin n_fail++; $display("[TB] FAIL refill_victim_keep got=%h/%0b exp=%h/0", rsp_addr, rsp_error, {36'h502, 6'h00}); end
    drain();
  endtask

  task automatic test_fill_inval();
    do_fill(36'h401, 36'h901);
    fill_valid = 1'b1; fill_va_page = 36'h400; fill_pa_page = 36'h900; inval_all = 1'b1;
    tick();
    fill_valid = 1'b0; inval_all = 1'b0;
    issue({36'h400, 6'h00}, 1'b1, 1'b1, 8'h10);
    tick();
    n_checks++; if (rsp_error !== 1'b1) begin n_fail++; $display("[TB] FAIL inval_drops_fill got_err=%0b exp=1", rsp_error); end
    issue({36'h401, 6'h00}, 1'b1, 1'b1, 8'h11);
    tick();
    n_checks++; if (rsp_error !== 1'b1) begin n_fail++; $display("[TB] FAIL inval_clears got_err=%0b exp=1", rsp_error); end
    drain();
  endtask

  task automatic test_fill_vs_s1();
    req_addr = {36'h600, 6'h11}; req_addr_is_virtual = 1'b1; req_is_speculative = 1'b1;
    req_tag = 8'h61; req_valid = 1'b1;
    tick();
    req_tag = 8'h62;
    fill_valid = 1'b1; fill_va_page = 36'h600; fill_pa_page = 36'hC00;
    tick();
    req_valid = 1'b0; fill_valid = 1'b0;
    n_checks++; if (rsp_error !== 1'b1 || rsp_tag !== 8'h61) begin n_fail++; $display("[TB] FAIL fill_same_cycle_miss got=%0b/%h exp=1/61", rsp_error, rsp_tag); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_addr !== {36'hC00, 6'h11} || rsp_tag !== 8'h62) begin
      n_fail++; $display("[TB] FAIL fill_next_hit got=%0b/%0b/%h/%h exp=1/0/%h/62", rsp_valid, rsp_error, rsp_addr, rsp_tag, {36'hC00, 6'h11});
    end
    drain();
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    drain();
    got_q.delete(); exp_q.delete();
    rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_valid = 1'b1; req_tag = 8'(k);
      req_addr = {36'h600 + 36'($urandom_range(0, 1)), 6'($urandom)};
      req_addr_is_virtual = 1'($urandom); req_is_speculative = 1'b1;
      tick();
      accepted += int'(last_acc);
    end
    req_valid = 1'b0;
    n_checks++; if (accepted !== OD) begin n_fail++; $display("[TB] FAIL bp_accepted got=%0d exp=%0d", accepted, OD); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_low got=%0b exp=0", req_ready); end
    drain();
    n_checks++; if (got_q.size() !== OD) begin n_fail++; $display("[TB] FAIL bp_rsp_count got=%0d exp=%0d", got_q.size(), OD); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_q[i].tag !== 8'(i)) begin
        n_fail++; $display("[TB] FAIL bp_rsp_%0d got=%h/%0b/%h exp=%h/%0b/%h", i, got_q[i].addr, got_q[i].err, got_q[i].tag, exp_q[i].addr, exp_q[i].err, i[7:0]);
      end
    end
    got_q.delete(); exp_q.delete();
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_tag = 8'(8'h80 + k); req_addr = 42'(k); req_addr_is_virtual = 1'b0;
      tick();
    end
    reset_n = 1'b0;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_rsp_valid got=%0b exp=0", rsp_valid); end
    reset_n = 1'b1; req_valid = 1'b0;
    tick();
    n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_idle got=%0b/%0b exp=1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_random();
    int dups = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      fill_valid   = ($urandom_range(0, 3) == 0);
      fill_va_page = 36'h700 + 36'($urandom_range(0, 23));
      fill_pa_page = {4'h0, 32'($urandom)};
      inval_all    = ($urandom_range(0, 79) == 0);
      req_valid    = ($urandom_range(0, 3) != 0);
      req_addr     = {36'h700 + 36'($urandom_range(0, 23)), 6'($urandom)};
      req_addr_is_virtual = ($urandom_range(0, 7) != 0);
      req_is_speculative  = 1'($urandom);
      req_tag      = 8'($urandom);
      rsp_ready    = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL rand_rsp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("[TB] FAIL rand_rsp_%0d got=%h/%0b/%h exp=%h/%0b/%h", i, got_q[i].addr, got_q[i].err, got_q[i].tag, exp_q[i].addr, exp_q[i].err, exp_q[i].tag);
      end
    end
    n_checks++; if (hit_count !== m_hits) begin n_fail++; $display("[TB] FAIL rand_hits got=%0d exp=%0d", hit_count, m_hits); end
    n_checks++; if (miss_count !== m_misses) begin n_fail++; $display("[TB] FAIL rand_misses got=%0d exp=%0d", miss_count, m_misses); end
    n_checks++; if (fatal_miss !== m_fatal) begin n_fail++; $display("[TB] FAIL rand_fatal got=%0b exp=%0b", fatal_miss, m_fatal); end
    for (int i = 0; i < NE; i++)
      for (int j = i + 1; j < NE; j++)
        if (dut.tlb_valid_q[i] && dut.tlb_valid_q[j] && dut.tlb_vpn_q[i] == dut.tlb_vpn_q[j]) dups++;
    n_checks++; if (dups !== 0) begin n_fail++; $display("[TB] FAIL rand_tlb_dedup got=%0d duplicate pairs exp=0", dups); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < NE; i++) begin m_valid[i] = 1'b0; m_vpn[i] = '0; m_ppn[i] = '0; end
    m_victim = 0; m_hits = '0; m_misses = '0; m_fatal = 1'b0; last_acc = 1'b0;
    $display("[TB] starting mpf_vtp_tlb_port_responder bench");
    test_reset();
    test_basic_hit();
    test_miss();
    test_passthrough();
    test_replacement();
    test_fill_inval();
    test_fill_vs_s1();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
